// File: rtl/ram_port_arbiter_if.sv
// Client-side request/grant bundle for one port of the table RAM arbiter.
// The client drives the request fields; the arbiter returns grant and read-valid.
interface ram_port_arbiter_if #(
    parameter int DataWidth   = 32,
    parameter int RAMAddWidth = 2
);
    logic                   req;
    logic                   we;
    logic [RAMAddWidth-1:0] addr;
    logic [DataWidth-1:0]   wdata;
    logic                   gnt;
    logic                   rvalid;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing RAM port A between the lookup and update clients.
// Clears every RAM word after reset, then grants with registered RAM controls.
module ram_port_arbiter #(
    parameter int DataWidth   = 32,
    parameter int RAMAddWidth = 2,
    parameter int DataDepth   = 4,
    parameter int ReadLatency = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    ram_port_arbiter_if.slave      c0,
    ram_port_arbiter_if.slave      c1,
    output logic [DataWidth-1:0]   rdata,
    output logic                   init_done,
    output logic [RAMAddWidth-1:0] address_a,
    output logic [DataWidth-1:0]   data_a,
    output logic                   rden_a,
    output logic                   wren_a,
    input  logic [DataWidth-1:0]   q_a
);
    localparam int CntWidth = RAMAddWidth + 1;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t                 state, state_nxt;
    logic [CntWidth-1:0]    init_cnt, cnt_nxt;
    logic                   rr, rr_nxt;
    logic [1:0]             gnt, gnt_nxt;
    logic                   rden_nxt, wren_nxt;
    logic                   rd_id, id_nxt;
    logic [RAMAddWidth-1:0] addr_nxt;
    logic [DataWidth-1:0]   data_nxt;
    logic                   sel;
    logic [ReadLatency-1:0] pipe_v, pipe_id;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = init_cnt;
        rr_nxt    = rr;
        gnt_nxt   = 2'b00;
        rden_nxt  = 1'b0;
        wren_nxt  = 1'b0;
        id_nxt    = rd_id;
        addr_nxt  = address_a;
        data_nxt  = data_a;
        sel       = 1'b0;
        unique case (state)
            INIT: begin
                if (init_cnt == CntWidth'(DataDepth)) begin
                    state_nxt = RUN;
                end else begin
                    wren_nxt = 1'b1;
                    addr_nxt = init_cnt[RAMAddWidth-1:0];
                    data_nxt = '0;
                    cnt_nxt  = init_cnt + CntWidth'(1);
                end
            end
            RUN: begin
                // rr names the favoured client when both are pending
                sel = (c0.req & c1.req) ? rr : c1.req;
                if (c0.req | c1.req) begin
                    gnt_nxt  = sel ? 2'b10 : 2'b01;
                    rr_nxt   = ~sel;
                    id_nxt   = sel;
                    wren_nxt = sel ? c1.we : c0.we;
                    rden_nxt = ~wren_nxt;
                    addr_nxt = sel ? c1.addr : c0.addr;
                    if (wren_nxt) begin
                        data_nxt = sel ? c1.wdata : c0.wdata;
                    end
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT;
            init_cnt  <= '0;
            rr        <= 1'b0;
            gnt       <= 2'b00;
            rden_a    <= 1'b0;
            wren_a    <= 1'b0;
            rd_id     <= 1'b0;
            address_a <= '0;
            data_a    <= '0;
        end else begin
            state     <= state_nxt;
            init_cnt  <= cnt_nxt;
            rr        <= rr_nxt;
            gnt       <= gnt_nxt;
            rden_a    <= rden_nxt;
            wren_a    <= wren_nxt;
            rd_id     <= id_nxt;
            address_a <= addr_nxt;
            data_a    <= data_nxt;
        end
    end

    // {valid, client} tracks each read until q_a carries its data
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_v  <= '0;
            pipe_id <= '0;
        end else begin
            pipe_v[0]  <= rden_a;
            pipe_id[0] <= rd_id;
            for (int i = 1; i < ReadLatency; i++) begin
                pipe_v[i]  <= pipe_v[i-1];
                pipe_id[i] <= pipe_id[i-1];
            end
        end
    end

    assign init_done = (state == RUN);
    assign c0.gnt    = gnt[0];
    assign c1.gnt    = gnt[1];
    assign c0.rvalid = pipe_v[ReadLatency-1] & ~pipe_id[ReadLatency-1];
    assign c1.rvalid = pipe_v[ReadLatency-1] & pipe_id[ReadLatency-1];
    assign rdata     = pipe_v[ReadLatency-1] ? q_a : '0;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a registered two-stage RAM model.
// Read expectations are queued per client at issue and popped on rvalid.
module tb_ram_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 2;
    localparam int DD = 4;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] rdata, data_a, q_a, q1;
    logic [AW-1:0] address_a;
    logic          init_done, rden_a, wren_a;

    always #5 clk = ~clk;

    ram_port_arbiter_if #(.DataWidth(DW), .RAMAddWidth(AW)) c0_if ();
    ram_port_arbiter_if #(.DataWidth(DW), .RAMAddWidth(AW)) c1_if ();

    ram_port_arbiter #(
        .DataWidth(DW), .RAMAddWidth(AW),
        .DataDepth(DD), .ReadLatency(RL)
    ) dut (
        .clk(clk), .reset(reset),
        .c0(c0_if), .c1(c1_if),
        .rdata(rdata), .init_done(init_done),
        .address_a(address_a), .data_a(data_a),
        .rden_a(rden_a), .wren_a(wren_a), .q_a(q_a)
    );

    logic [DW-1:0] mem [2**AW];
    bit            fill = 1'b1;

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= 32'hA5A5_A500 + i;
            fill <= 1'b0;
        end else if (wren_a) begin
            mem[address_a] <= data_a;
        end
        if (rden_a) q1 <= mem[address_a];
        q_a <= q1;
    end

    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            rv0_n = 0;
    int            rv1_n = 0;
    int            rv0_cyc = -1;
    int            rv1_cycs[$];
    logic [DW-1:0] shadow [2**AW];
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (c0_if.rvalid) begin
                rv0_n++;
                rv0_cyc = cyc;
                check("c0_rv_pending", exp_q0.size() > 0, 1'b1);
                if (exp_q0.size() > 0) check("c0_rdata", rdata, exp_q0.pop_front());
            end
            if (c1_if.rvalid) begin
                rv1_n++;
                rv1_cycs.push_back(cyc);
                check("c1_rv_pending", exp_q1.size() > 0, 1'b1);
                if (exp_q1.size() > 0) check("c1_rdata", rdata, exp_q1.pop_front());
            end
            if (c0_if.gnt | c1_if.gnt) begin
                check("gnt_onehot", c0_if.gnt & c1_if.gnt, 1'b0);
                check("gnt_after_init", init_done, 1'b1);
            end
        end
    end

    task automatic drive(input int cl, input logic r, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (cl == 0) begin
            c0_if.req = r; c0_if.we = we; c0_if.addr = a; c0_if.wdata = d;
        end else begin
            c1_if.req = r; c1_if.we = we; c1_if.addr = a; c1_if.wdata = d;
        end
    endtask

    task automatic idle(input int cl);
        drive(cl, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic issue(input int cl, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int g);
        int n = 0;
        drive(cl, 1'b1, we, a, d);
        if (we) shadow[a] = d;
        else if (cl == 0) exp_q0.push_back(shadow[a]);
        else exp_q1.push_back(shadow[a]);
        g = -1;
        while (n < 40 && g < 0) begin
            @(negedge clk);
            n++;
            if ((cl == 0) ? c0_if.gnt : c1_if.gnt) g = cyc;
        end
        if (g < 0) check("gnt_wait", 1'b0, 1'b1);
    endtask

    task automatic check_init(input string tag);
        int wa[$];
        int last = -1;
        int done = -1;
        for (int i = 0; i < 12 && done < 0; i++) begin
            @(negedge clk);
            if (wren_a) begin
                wa.push_back(int'(address_a));
                check({tag, "_init_data"}, data_a, '0);
                last = cyc;
            end
            if (init_done) done = cyc;
        end
        check({tag, "_init_writes"}, wa.size(), DD);
        for (int i = 0; i < wa.size(); i++) check({tag, "_init_addr"}, wa[i], i);
        check({tag, "_init_done_cyc"}, done, last + 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(0);
        idle(1);
        exp_q0.delete();
        exp_q1.delete();
        foreach (shadow[i]) shadow[i] = '0;
        @(negedge clk);
        check("rst_init_done_drop", init_done, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        int g, rel, n0, n1;
        int ga[3];
        int gb[3];
        idle(0);
        idle(1);
        foreach (shadow[i]) shadow[i] = '0;
        repeat (2) @(negedge clk);
        check("rst_wren", wren_a, 1'b0);
        check("rst_rden", rden_a, 1'b0);
        check("rst_init_done", init_done, 1'b0);
        check("rst_gnt", {c1_if.gnt, c0_if.gnt}, 2'b00);
        check("rst_rvalid", {c1_if.rvalid, c0_if.rvalid}, 2'b00);
        check("rst_addr", address_a, '0);
        check("rst_data", data_a, '0);
        check("rst_rdata", rdata, '0);
        reset = 1'b0;

        // clear sequence, then a cleared word reads back zero
        check_init("t1");
        issue(0, 1'b0, 2'd2, '0, g);
        idle(0);

        // write then read same address, latency and routing
        issue(0, 1'b1, 2'd1, 32'hDEAD_BEEF, g);
        n1 = rv1_n;
        issue(0, 1'b0, 2'd1, '0, g);
        idle(0);
        repeat (4) @(negedge clk);
        check("t2_latency", rv0_cyc, g + RL);
        check("t2_no_c1_rvalid", rv1_n, n1);

        // preload, then c1 back-to-back reads
        for (int i = 0; i < 4; i++) issue(0, 1'b1, 2'(i), 32'h10 + i, g);
        idle(0);
        rv1_cycs.delete();
        for (int i = 0; i < 4; i++) issue(1, 1'b0, 2'(i), '0, g);
        idle(1);
        repeat (5) @(negedge clk);
        check("t4_rv_count", rv1_cycs.size(), 4);
        for (int i = 1; i < rv1_cycs.size(); i++)
            check("t4_rv_consec", rv1_cycs[i], rv1_cycs[0] + i);

        // both clients contend: strict alternation starting with c0
        fork
            begin
                for (int i = 0; i < 3; i++) issue(0, 1'b0, 2'(i), '0, ga[i]);
                idle(0);
            end
            begin
                for (int j = 0; j < 3; j++) issue(1, 1'b0, 2'(3 - j), '0, gb[j]);
                idle(1);
            end
        join
        for (int i = 0; i < 3; i++) check("t3_c1_after_c0", gb[i], ga[i] + 1);
        for (int i = 1; i < 3; i++) check("t3_c0_spacing", ga[i], ga[i-1] + 2);
        repeat (4) @(negedge clk);

        // reset right after a read grant drops the return
        issue(0, 1'b1, 2'd1, 32'h55, g);
        issue(0, 1'b0, 2'd1, '0, g);
        idle(0);
        n0 = rv0_n;
        @(negedge clk);
        do_reset();
        check_init("t6");
        check("t6_dropped_rvalid", rv0_n, n0);
        issue(0, 1'b0, 2'd1, '0, g);
        idle(0);
        repeat (4) @(negedge clk);

        // requests raised during the clear sequence
        do_reset();
        rel = cyc;
        fork
            issue(0, 1'b0, 2'd2, '0, ga[0]);
            issue(1, 1'b0, 2'd3, '0, gb[0]);
        join
        idle(0);
        idle(1);
        check("t5_no_early_gnt", ga[0] > rel + DD + 1, 1'b1);
        check("t5_c0_first", gb[0], ga[0] + 1);

        repeat (6) @(negedge clk);
        check("drain_q0", exp_q0.size(), 0);
        check("drain_q1", exp_q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
